// File: rtl/edg_zbt_writer.sv
// edg_zbt_writer: captures the processed pixel-pair stream of one video frame
// and writes it, one 36-bit pair per word, into ZBT SRAM starting at BASE_ADDR.
//
// States: IDLE -> ARM (start) -> CAPTURE (frame origin) -> DONE (last word).
// Build option: define EDG_WR_CONT_EN for continuous capture. DONE then
// re-arms, the address reloads to BASE_ADDR and busy stays high.
//
// Handshake: none. zbt_we is a one-cycle strobe per word, and zbt_addr and
// zbt_data are valid in that same cycle. There is no back-pressure, so the
// SRAM must accept one write every cycle that zbt_we is high.
//
// dbg_state exposes the FSM state so that external checkers can bind to it.

module edg_zbt_writer #(
   parameter int          H_ACTIVE  = 640,
   parameter int          V_ACTIVE  = 480,
   parameter int          PIPE_DLY  = 4,
   parameter logic [18:0] BASE_ADDR = 19'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic [35:0] two_proc_pixs,
   input  logic        start,
   output logic [18:0] zbt_addr,
   output logic        zbt_we,
   output logic [35:0] zbt_data,
   output logic        busy,
   output logic        frame_done,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // The processed pair lags the raw counters by PIPE_DLY cycles. The capture
   // window is therefore shifted right by that amount.
   localparam logic [11:0] H_LO      = 12'(PIPE_DLY);
   localparam logic [11:0] H_HI      = 12'(PIPE_DLY + H_ACTIVE);
   localparam logic [10:0] V_LIM     = 11'(V_ACTIVE);
   localparam logic [18:0] LAST_WORD = 19'((V_ACTIVE * H_ACTIVE) / 2 - 1);

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [18:0] addr_q, addr_d;
   logic [18:0] wr_ptr_q, wr_ptr_d;   // address that the next write will use
   logic [18:0] word_cnt_q, word_cnt_d;
   logic [35:0] data_q, data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        qual;
   logic        last_word;

   // Qualify a word in CAPTURE when the counters fall inside the delayed
   // active window and hcount is even. The even hcount marks a complete pair.
   always_comb begin
      qual = (state_q == CAPTURE)
             && ({1'b0, vcount} < V_LIM)
             && ({1'b0, hcount} >= H_LO)
             && ({1'b0, hcount} <  H_HI)
             && !hcount[0];
      last_word = qual && (word_cnt_q == LAST_WORD);
   end

   // Next-state logic for the FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ARM;
         ARM:     if ((hcount == 11'd0) && (vcount == 10'd0)) state_d = CAPTURE;
         CAPTURE: if (last_word) state_d = DONE;
         DONE: begin
`ifdef EDG_WR_CONT_EN
            state_d = ARM;
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values for the datapath and the registered outputs.
   always_comb begin
      we_d       = qual;
      addr_d     = addr_q;
      wr_ptr_d   = wr_ptr_q;
      word_cnt_d = word_cnt_q;
      data_d     = data_q;

      if (qual) begin
         // The write appears one cycle later, carrying the pair unmodified.
         data_d     = two_proc_pixs;
         addr_d     = wr_ptr_q;
         wr_ptr_d   = wr_ptr_q + 19'd1;   // 19-bit wrap is intentional
         word_cnt_d = word_cnt_q + 19'd1;
      end else if (state_q != CAPTURE) begin
         // Outside capture the write pointer and the word count are rewound,
         // so the next frame always begins at BASE_ADDR.
         wr_ptr_d   = BASE_ADDR;
         word_cnt_d = 19'd0;
      end

`ifdef EDG_WR_CONT_EN
      // The trailing write is presented during DONE. After it, the visible
      // address returns to the frame base for the next frame.
      if (state_q == DONE) addr_d = BASE_ADDR;
      busy_d = (state_d == ARM) || (state_d == CAPTURE) || (state_d == DONE);
`else
      busy_d = (state_d == ARM) || (state_d == CAPTURE);
`endif
      done_d = (state_d == DONE);
   end

   // State and output registers, with synchronous reset that may be applied
   // mid-frame. Reset discards any partial frame without raising frame_done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         addr_q     <= BASE_ADDR;
         wr_ptr_q   <= BASE_ADDR;
         word_cnt_q <= 19'd0;
         data_q     <= 36'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wr_ptr_q   <= wr_ptr_d;
         word_cnt_q <= word_cnt_d;
         data_q     <= data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign zbt_addr   = addr_q;
   assign zbt_we     = we_q;
   assign zbt_data   = data_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign dbg_state  = state_q;

endmodule

// File: doc/edg_zbt_writer.md
EDG_ZBT_WRITER -- requirements
Module: edg_zbt_writer

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line; even.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter PIPE_DLY, default 4: hcount cycles from the raw pixel pair entering edge detection to the processed pair being valid on two_proc_pixs; even.
REQ-004 Parameter BASE_ADDR, default 0: first ZBT word address of the destination frame.
REQ-005 clk  input  1  system clock; all logic on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 hcount  input  11  horizontal pixel counter, same timing as the edge-detect stage.
REQ-008 vcount  input  10  vertical line counter.
REQ-009 two_proc_pixs  input  36  processed pair, {pix2[17:0], pix1[17:0]}, 6:6:6 RGB each.
REQ-010 start  input  1  one-cycle request to capture one frame.
REQ-011 zbt_addr  output  19  ZBT write word address.
REQ-012 zbt_we  output  1  ZBT write enable, one cycle per word.
REQ-013 zbt_data  output  36  ZBT write data.
REQ-014 busy  output  1  high in ARM or CAPTURE.
REQ-015 frame_done  output  1  one-cycle pulse when the last word of a frame is written.

Function
REQ-016 The FSM SHALL have states IDLE, ARM, CAPTURE and DONE.
REQ-017 IDLE->ARM on start=1; start in any other state SHALL be ignored.
REQ-018 ARM->CAPTURE on the cycle where hcount==0 and vcount==0; no write occurs in that cycle.
REQ-019 In CAPTURE, a word SHALL be qualified when vcount<V_ACTIVE, PIPE_DLY<=hcount<PIPE_DLY+H_ACTIVE, and hcount[0]==0.
REQ-020 On each qualified cycle, the next cycle SHALL have zbt_we=1 and zbt_data equal to two_proc_pixs sampled in the qualified cycle, unmodified.
REQ-021 zbt_addr SHALL start at BASE_ADDR for the first word of a frame and increment by 1 after each write; it holds its value between writes.
REQ-022 Each line SHALL produce exactly H_ACTIVE/2 writes; each frame SHALL produce exactly V_ACTIVE*H_ACTIVE/2 writes.
REQ-023 A word counter SHALL track writes; when the final write of the frame issues, the FSM SHALL enter DONE.
REQ-024 DONE SHALL last one cycle with frame_done=1, then go to IDLE.
REQ-025 Address arithmetic SHALL be 19-bit modulo; wrap past 19'h7FFFF is permitted and is not flagged.
REQ-026 zbt_we SHALL be 0 in IDLE, ARM and DONE, except for the trailing write of the final qualified cycle.
REQ-027 busy SHALL be 1 in ARM and CAPTURE and 0 otherwise.
REQ-028 Outputs SHALL be registered; the only combinational paths are to FSM next-state logic.

Reset
REQ-029 When reset=1 at a clock edge, the block SHALL return to IDLE from any state, including mid-frame.
REQ-030 Reset values SHALL be: zbt_we=0, zbt_addr=BASE_ADDR, zbt_data=0, busy=0, frame_done=0, word counter=0.
REQ-031 No partial-frame frame_done SHALL be generated after a reset.

Configuration
REQ-032 With macro EDG_WR_CONT_EN defined, DONE SHALL go to ARM instead of IDLE, and the address SHALL reload to BASE_ADDR, giving continuous frame capture until reset.
REQ-033 With EDG_WR_CONT_EN defined, busy SHALL stay 1 through DONE.
REQ-034 Without EDG_WR_CONT_EN, capture SHALL be single-shot as in REQ-024.

Verification
REQ-035 Scenario: reset, then start with default parameters; drive hcount 0..799 and vcount 0..524 -> exactly 153600 zbt_we pulses, addresses 0..153599, and one frame_done.
REQ-036 Scenario: first word check. two_proc_pixs=36'hABCDE1234 at hcount=4, vcount=0 -> zbt_we=1, zbt_addr=0, zbt_data=36'hABCDE1234 at hcount=5.
REQ-037 Scenario: drive hcount=5 (odd) and hcount=644 (out of window) -> no zbt_we.
REQ-038 Scenario: start arrives at vcount=100 -> no writes until the next hcount=0, vcount=0 frame origin; busy=1 while waiting.
REQ-039 Scenario: reset asserted at vcount=200 -> next cycle zbt_we=0, busy=0, zbt_addr=BASE_ADDR, and no frame_done; a new start then captures a full frame from address BASE_ADDR.
REQ-040 Scenario: with EDG_WR_CONT_EN and BASE_ADDR=19'h40000, run two frames -> two frame_done pulses, both frames written at 19'h40000..19'h657FF, and busy never drops.
